// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and small helpers for the HD44780 bus executor.
package lcd_pkg;

  // Operation codes presented by the upstream command sequencer.
  localparam logic [3:0] OP_INIT  = 4'd0;
  localparam logic [3:0] OP_CMD   = 4'd1;
  localparam logic [3:0] OP_CHAR  = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;
  localparam logic [3:0] OP_GOTO  = 4'd4;
  localparam logic [3:0] OP_NOP   = 4'd15;

  // HD44780 instruction bytes.
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow)
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_DDRAM    = 8'h80;  // set DDRAM address base

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POWERUP = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  // Byte written at each step of the power-on init sequence.
  function automatic logic [7:0] init_byte(input logic [1:0] step);
    logic [7:0] b;
    case (step)
      2'd0:    b = LCD_FUNC_SET;
      2'd1:    b = LCD_DISP_ON;
      2'd2:    b = LCD_CLEAR;
      2'd3:    b = LCD_ENTRY;
      default: b = LCD_FUNC_SET;
    endcase
    return b;
  endfunction

  // Clear-display and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic [7:0] b);
    return (b == 8'h01) || (b == 8'h02);
  endfunction

endpackage

// File: rtl/lcd_bus_executor.sv
// HD44780 8-bit write-only bus driver: latches one op when idle, sequences
// RS/DATA setup, the EN strobe, hold and execution wait, then reports ready.
module lcd_bus_executor
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 16,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_SHORT_CYC = 2500,
  parameter int WAIT_LONG_CYC  = 100000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [3:0] op,
  input  logic [7:0] data,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       rdy
);

  localparam int MAX_A   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_B   = (HOLD_CYC > WAIT_SHORT_CYC) ? HOLD_CYC : WAIT_SHORT_CYC;
  localparam int MAX_C   = (WAIT_LONG_CYC > POWERUP_CYC) ? WAIT_LONG_CYC : POWERUP_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  // The counter only ever holds N-1, so clog2(max N) bits are enough.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LD   = CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD    = CNT_W'(WAIT_LONG_CYC - 1);
  localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic             init_q, init_d;
  logic             long_q, long_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             rdy_q, rdy_d;

  // State, counter, latched byte and registered pin values; reset aborts everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      step_q  <= 2'd0;
      init_q  <= 1'b0;
      long_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      init_q  <= init_d;
      long_q  <= long_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next state: acceptance, phase sequencing and the init-byte walk; enb low holds all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    init_d  = init_q;
    long_d  = long_q;
    rs_d    = rs_q;
    data_d  = data_q;
    if (enb) begin
      case (state_q)
        ST_IDLE: begin
          if (op <= OP_GOTO) begin
            step_d = 2'd0;
            init_d = (op == OP_INIT);
            if (op == OP_INIT) begin
              // Bus keeps its old value until the first init byte is set up.
              state_d = ST_POWERUP;
              cnt_d   = POWERUP_LD;
            end else begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
            end
            case (op)
              OP_CMD: begin
                rs_d   = 1'b0;
                data_d = data;
                long_d = is_long_cmd(data);
              end
              OP_CHAR: begin
                rs_d   = 1'b1;
                data_d = data;
                long_d = 1'b0;
              end
              OP_CLEAR: begin
                rs_d   = 1'b0;
                data_d = LCD_CLEAR;
                long_d = 1'b1;
              end
              OP_GOTO: begin
                rs_d   = 1'b0;
                data_d = LCD_DDRAM | {1'b0, data[6:0]};
                long_d = 1'b0;
              end
              default: begin
                long_d = 1'b0;
              end
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_POWERUP: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            rs_d    = 1'b0;
            data_d  = init_byte(2'd0);
            long_d  = (init_byte(2'd0) == LCD_CLEAR);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SETUP: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_PULSE;
            cnt_d   = PULSE_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_WAIT;
            cnt_d   = long_q ? LONG_LD : SHORT_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (init_q && (step_q != 2'd3)) begin
            step_d  = step_q + 2'd1;
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            rs_d    = 1'b0;
            data_d  = init_byte(step_q + 2'd1);
            long_d  = (init_byte(step_q + 2'd1) == LCD_CLEAR);
          end else begin
            state_d = ST_IDLE;
            init_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Strobe and ready follow the upcoming state so both are registered with it.
  always_comb begin
    en_d  = (state_d == ST_PULSE);
    rdy_d = (state_d == ST_IDLE);
  end

  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_DATA = data_q;
  assign rdy      = rdy_q;

endmodule

// File: tb/tb_lcd_bus_executor.sv
// Bench for lcd_bus_executor: directed steps plus randomized ops, checked each
// cycle against a trace model built from the byte/phase timing rules.
module tb_lcd_bus_executor;

  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_WS    = 5;
  localparam int P_WL    = 9;
  localparam int P_PU    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic [3:0] op = 4'd15;
  logic [7:0] data = 8'h00;
  logic       LCD_RS, LCD_RW, LCD_EN, rdy;
  logic [7:0] LCD_DATA;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       rdy;
    logic       en;
    logic       rs;
    logic [7:0] d;
  } obs_t;

  obs_t q[$];
  obs_t cur = '{rdy: 1'b1, en: 1'b0, rs: 1'b0, d: 8'h00};

  lcd_bus_executor #(
    .SETUP_CYC(P_SETUP), .EN_HIGH_CYC(P_EN), .HOLD_CYC(P_HOLD),
    .WAIT_SHORT_CYC(P_WS), .WAIT_LONG_CYC(P_WL), .POWERUP_CYC(P_PU)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .op(op), .data(data),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA(LCD_DATA), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append the pin trace of one byte write: setup, strobe, hold, execution wait.
  task automatic push_byte(input logic rs, input logic [7:0] b, input bit long_w);
    int w;
    w = long_w ? P_WL : P_WS;
    for (int i = 0; i < P_SETUP; i++) q.push_back('{1'b0, 1'b0, rs, b});
    for (int i = 0; i < P_EN; i++)    q.push_back('{1'b0, 1'b1, rs, b});
    for (int i = 0; i < P_HOLD; i++)  q.push_back('{1'b0, 1'b0, rs, b});
    for (int i = 0; i < w; i++)       q.push_back('{1'b0, 1'b0, rs, b});
  endtask

  // Build the whole expected trace for an accepted op, ending with the ready cycle.
  task automatic build(input logic [3:0] o, input logic [7:0] d);
    logic [7:0] seq [4];
    obs_t last;
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01; seq[3] = 8'h06;
    case (o)
      4'd0: begin
        for (int i = 0; i < P_PU; i++) q.push_back('{1'b0, 1'b0, cur.rs, cur.d});
        for (int i = 0; i < 4; i++) push_byte(1'b0, seq[i], seq[i] == 8'h01);
      end
      4'd1: push_byte(1'b0, d, (d == 8'h01) || (d == 8'h02));
      4'd2: push_byte(1'b1, d, 1'b0);
      4'd3: push_byte(1'b0, 8'h01, 1'b1);
      default: push_byte(1'b0, {1'b1, d[6:0]}, 1'b0);
    endcase
    last = q[q.size() - 1];
    q.push_back('{1'b1, 1'b0, last.rs, last.d});
  endtask

  // Advance the reference by one clock edge using the inputs the DUT sees.
  task automatic model_edge();
    if (!rst) begin
      q.delete();
      cur = '{1'b1, 1'b0, 1'b0, 8'h00};
    end else if (enb) begin
      if (q.size() == 0) begin
        if (op <= 4'd4) begin
          build(op, data);
          cur = q.pop_front();
        end
      end else begin
        cur = q.pop_front();
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("rdy", 32'(rdy), 32'(cur.rdy));
    chk("en", 32'(LCD_EN), 32'(cur.en));
    chk("rs", 32'(LCD_RS), 32'(cur.rs));
    chk("rw", 32'(LCD_RW), 32'd0);
    chk("data", 32'(LCD_DATA), 32'(cur.d));
    @(negedge clk);
  endtask

  // Run until rdy is seen high, counting busy cycles and EN pulses; bounded.
  task automatic run_busy(input int bound, output int n, output int pulses);
    logic prev;
    n = 0;
    pulses = 0;
    prev = LCD_EN;
    while (rdy !== 1'b1 && n < bound) begin
      cyc();
      n++;
      if (LCD_EN === 1'b1 && prev !== 1'b1) pulses++;
      prev = LCD_EN;
    end
    chk("busy_timeout", 32'(rdy), 32'd1);
  endtask

  initial begin
    int n, pulses, st, k;

    // Reset, then NOP held: idle pins forever.
    rst = 1'b0; op = 4'd15;
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) cyc();

    // CHAR 0x41: 12 busy clocks, one 3-clock pulse.
    op = 4'd2; data = 8'h41;
    cyc();
    op = 4'd15; data = 8'h5A;
    run_busy(100, n, pulses);
    chk("char_latency", 32'(n), 32'd12);
    chk("char_pulses", 32'(pulses), 32'd1);
    cyc();

    // INIT: powerup then four bytes.
    op = 4'd0;
    cyc();
    op = 4'd1; data = 8'h01;
    run_busy(200, n, pulses);
    chk("init_latency", 32'(n), 32'(P_PU + 4 * (P_SETUP + P_EN + P_HOLD) + 3 * P_WS + P_WL));
    chk("init_pulses", 32'(pulses), 32'd4);
    op = 4'd15;
    cyc();

    // GOTO 0xFF then CLEAR.
    op = 4'd4; data = 8'hFF;
    cyc();
    op = 4'd15;
    run_busy(100, n, pulses);
    chk("goto_data", 32'(LCD_DATA), 32'h80 | 32'h7F);
    op = 4'd3; data = 8'h00;
    cyc();
    op = 4'd15;
    run_busy(100, n, pulses);
    chk("clear_latency", 32'(n), 32'(P_SETUP + P_EN + P_HOLD + P_WL));

    // Reset during the strobe, then a normal CHAR.
    op = 4'd2; data = 8'h33;
    cyc();
    op = 4'd15;
    k = 0;
    while (LCD_EN !== 1'b1 && k < 20) begin cyc(); k++; end
    chk("pulse_seen", 32'(LCD_EN), 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rst_en", 32'(LCD_EN), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_data", 32'(LCD_DATA), 32'h00);
    op = 4'd2; data = 8'h7E;
    cyc();
    op = 4'd15;
    run_busy(100, n, pulses);
    chk("post_rst_latency", 32'(n), 32'd12);

    // Freeze mid-pulse for 7 clocks.
    op = 4'd2; data = 8'h21;
    cyc();
    op = 4'd15;
    n = 0; st = 0;
    while (rdy !== 1'b1 && n < 200) begin
      if (LCD_EN === 1'b1 && st < 7) begin enb = 1'b0; st++; end
      else enb = 1'b1;
      cyc();
      n++;
    end
    enb = 1'b1;
    chk("stall_latency", 32'(n), 32'd19);

    // Invalid op 7 is never accepted.
    op = 4'd7; data = 8'hAA;
    for (int i = 0; i < 12; i++) cyc();
    chk("op7_rdy", 32'(rdy), 32'd1);

    // Randomized ops with random enb stalls and input noise while busy.
    for (int t = 0; t < 40; t++) begin
      op = 4'($urandom_range(0, 15));
      data = 8'($urandom);
      enb = ($urandom_range(0, 7) != 0);
      cyc();
      k = 0;
      while (q.size() != 0 && k < 500) begin
        op = 4'($urandom_range(0, 15));
        data = 8'($urandom);
        enb = ($urandom_range(0, 7) != 0);
        cyc();
        k++;
      end
      chk("rand_timeout", 32'(k < 500), 32'd1);
    end
    enb = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_executor.md
Name: lcd_bus_executor

Overview:
- Low-level HD44780-compatible character-LCD bus driver; 8-bit write-only interface.
- Accepts one operation (opcode + byte) when idle.
- Generates RS/RW/EN/DATA timing and the post-write execution wait, then re-asserts ready.
- Sits between the LCD command sequencer (upstream, handshakes on ready) and the LCD pins.

Parameters:
- SETUP_CYC, 4: clocks RS/DATA are stable before EN rises.
- EN_HIGH_CYC, 16: clocks EN is held high.
- HOLD_CYC, 4: clocks RS/DATA are held after EN falls.
- WAIT_SHORT_CYC, 2500: execution wait after a normal byte (50 us at 50 MHz).
- WAIT_LONG_CYC, 100000: execution wait after clear-display 0x01 (2 ms).
- POWERUP_CYC, 750000: wait before the first init byte (15 ms).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: reset; synchronous, active-low.
- enb, input, 1: enable; low freezes state, counters and outputs.
- op, input, 4: operation code.
- data, input, 8: operand byte.
- LCD_RS, output, 1: register select (0 = command, 1 = data).
- LCD_RW, output, 1: read/write; constant 0.
- LCD_EN, output, 1: enable strobe.
- LCD_DATA, output, 8: LCD data bus.
- rdy, output, 1: high while idle and able to accept an op.

Behaviour:
- Reset (rst=0 at a rising clk):
  - LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0x00, rdy=1, state=IDLE.
  - Aborts any operation in progress; EN is low from the next edge.
- Opcodes:
  - 0 INIT: POWERUP_CYC wait, then writes 0x38, 0x0C, 0x01, 0x06 with RS=0. 0x01 uses WAIT_LONG_CYC; the others use WAIT_SHORT_CYC.
  - 1 CMD: write data with RS=0. Wait is WAIT_LONG_CYC if data is 0x01 or 0x02, else WAIT_SHORT_CYC.
  - 2 CHAR: write data with RS=1, WAIT_SHORT_CYC.
  - 3 CLEAR: write 0x01 with RS=0, WAIT_LONG_CYC.
  - 4 GOTO: write 0x80 | data[6:0] with RS=0, WAIT_SHORT_CYC.
  - 15 and 5..14: NOP. Not accepted; rdy stays 1.
- Acceptance: at a rising edge with rst=1, enb=1, state=IDLE and a valid op (0..4), op and data are latched and rdy=0 from that edge. Input changes after acceptance are ignored.
- FSM sequence: IDLE -> [POWERUP, INIT only] -> SETUP -> PULSE -> HOLD -> WAIT -> (next init byte ? SETUP : IDLE).
  - SETUP: RS and DATA driven, EN=0, for SETUP_CYC clocks.
  - PULSE: EN=1 for EN_HIGH_CYC clocks.
  - HOLD: EN=0, RS/DATA unchanged, for HOLD_CYC clocks.
  - WAIT: EN=0, for the selected wait length.
- Completion: on return to IDLE, rdy=1 on the same edge. LCD_DATA and LCD_RS keep their last values.
- Single-byte latency: rdy is low for exactly SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+WAIT clocks. The next op can be accepted on the edge where rdy rises.
- EN pulses: exactly one per byte written. RS/DATA never change while EN=1.
- enb=0: all counters and state hold; outputs hold their values (including EN=1 mid-pulse); no acceptance. Resume is seamless when enb returns high.
- Counters: wide enough for the maximum parameter (20 bits at defaults). Load N-1 and count down to 0, so each phase lasts exactly N clocks.

Decomposition:
- Shared package (lcd_pkg):
  - Opcode constants OP_INIT=0, OP_CMD=1, OP_CHAR=2, OP_CLEAR=3, OP_GOTO=4, OP_NOP=15.
  - LCD instruction constants 0x38, 0x0C, 0x01, 0x06, 0x80.
  - FSM state enum.
- Single module; no sub-module needed. Use one down-counter and a 2-bit init-step index.

Test Plan (sim parameters SETUP=2, EN_HIGH=3, HOLD=2, WAIT_SHORT=5, WAIT_LONG=9, POWERUP=10):
- Reset, then op=15 held -> rdy=1, EN=0, RS=0, RW=0, DATA=0x00 indefinitely.
- op=2, data=0x41 -> rdy low for 12 clocks. DATA=0x41 and RS=1 from the first cycle; one EN pulse lasting exactly 3 clocks, starting 2 clocks after acceptance.
- op=0 -> 10 idle clocks, then 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is the long wait; rdy rises after the 0x06 wait.
- op=4, data=0xFF -> DATA=0xFF (0x80|0x7F), RS=0. op=3 -> DATA=0x01 with the 9-clock wait.
- rst=0 asserted during PULSE -> next edge EN=0, rdy=1, DATA=0x00. A following op=2 is accepted normally.
- enb=0 for 7 clocks mid-PULSE -> EN stays 1 throughout and total latency grows by exactly 7. op=7 -> never accepted, rdy stays 1.
